// File: rtl/led_color_smoother.sv
`default_nettype none
// ============================================================================
// Module   : led_color_smoother
// Purpose  : Temporal smoothing of 24-bit LED colours. Each word is moved
//            toward the target by 1/2^SHIFT of the difference from the value
//            sent to the same LED position in the previous frame. Every lane
//            moves by at least 1 whenever it differs from its history.
//            History is kept in an internal NUM_LEDS-deep RAM.
// Ports    : sys_clk, sys_rst_n      - clock, async active-low reset
//            frame_start             - next accepted word is LED index 0
//            bypass                  - pass input through (RAM still written)
//            in_data/in_valid/in_ready    - input handshake (ready only in IDLE)
//            out_data/out_valid/out_ready - registered output handshake
//            frame_done              - 1-cycle pulse after the last LED's output
// Revision : 1.0 - initial release
// ============================================================================
module led_color_smoother #(
  parameter int NUM_LEDS = 120,
  parameter int IDX_W    = 8,
  parameter int SHIFT    = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        frame_start,
  input  logic        bypass,
  input  logic [23:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [23:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_done
);

  localparam int               ADDR_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_CALC  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [IDX_W-1:0] idx;          // index of the next word when no frame_start
  logic [IDX_W-1:0] eff_idx;      // index of the word in flight
  logic [IDX_W-1:0] eff_idx_nxt;
  logic             start_pending;
  logic             primed;       // a complete frame of history exists
  logic [23:0]      in_lat;
  logic             bypass_lat;
  logic [23:0]      prev_data;    // RAM read data (history for eff_idx)
  logic [23:0]      smooth_data;
  logic [23:0]      result;
  logic             accept;
  logic             out_fire;
  logic             last_word;

  logic [23:0]      mem [NUM_LEDS];

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_CALC;
      S_CALC:  state_nxt = S_OUT;
      S_OUT: begin
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept      = (state == S_IDLE) && in_valid;
  assign out_fire    = (state == S_OUT) && out_ready;
  // A frame_start coincident with the accept applies to that same word.
  assign eff_idx_nxt = (frame_start || start_pending) ? '0 : idx;
  assign last_word   = (eff_idx == LAST_IDX);

  // --------------------------------------------------------------------------
  // Datapath / control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idx           <= '0;
      eff_idx       <= '0;
      start_pending <= 1'b0;
      primed        <= 1'b0;
      in_lat        <= '0;
      bypass_lat    <= 1'b0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (accept) begin
        in_lat        <= in_data;
        bypass_lat    <= bypass;
        eff_idx       <= eff_idx_nxt;
        start_pending <= 1'b0;
      end else if (frame_start) begin
        // Remember the frame boundary until the next word is accepted.
        start_pending <= 1'b1;
      end

      if (state == S_CALC) begin
        out_data  <= result;
        out_valid <= 1'b1;
      end

      if (out_fire) begin
        out_valid <= 1'b0;
        if (last_word) begin
          idx        <= '0;
          frame_done <= 1'b1;
          primed     <= 1'b1;
        end else begin
          idx <= eff_idx + IDX_W'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // History RAM: not reset; primed guards against reading stale contents.
  // The read runs every cycle off eff_idx, so data latched at the FETCH edge
  // is valid throughout CALC.
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (state == S_CALC) begin
      mem[eff_idx[ADDR_W-1:0]] <= result;
    end
    prev_data <= mem[eff_idx[ADDR_W-1:0]];
  end

  // --------------------------------------------------------------------------
  // Per-lane IIR step. Working with |d| and a separate sign keeps everything
  // in 8 bits; prev +/- step cannot leave 0..255 because step <= |d|.
  // --------------------------------------------------------------------------
  for (genvar l = 0; l < 3; l++) begin : g_lane
    logic [7:0] prev_lane;
    logic [7:0] in_lane;
    logic       neg;
    logic [7:0] mag;
    logic [7:0] shifted;
    logic [7:0] step;

    assign prev_lane = prev_data[8*l +: 8];
    assign in_lane   = in_lat[8*l +: 8];
    assign neg       = (in_lane < prev_lane);
    assign mag       = neg ? (prev_lane - in_lane) : (in_lane - prev_lane);
    assign shifted   = mag >> SHIFT;
    assign step      = (mag == 8'd0)     ? 8'd0 :
                       (shifted == 8'd0) ? 8'd1 : shifted;
    assign smooth_data[8*l +: 8] = neg ? (prev_lane - step) : (prev_lane + step);
  end

  assign result = (primed && !bypass_lat) ? smooth_data : in_lat;

endmodule
`default_nettype wire
